// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - framebuffer geometry and scan arbiter state encoding
package fb_pkg;
  localparam int H_PIXELS        = 128;
  localparam int V_PIXELS        = 64;
  localparam int PAGES           = V_PIXELS / 8;
  localparam int BYTES_PER_FRAME = H_PIXELS * PAGES;
  localparam int COL_W           = $clog2(H_PIXELS);
  localparam int PAGE_W          = $clog2(PAGES);
  localparam int CNT_W           = $clog2(BYTES_PER_FRAME);

  typedef enum logic [2:0] {
    INIT_RST,
    INIT_WAIT,
    IDLE,
    RD,
    WR,
    GAP,
    CLR_RST,
    CLR_WAIT
  } fb_state_t;
endpackage

// File: rtl/fb_scan_arbiter_if.sv
// rtl/fb_scan_arbiter_if.sv - framebuffer memory port between arbiter (master) and framebuffer (slave)
interface fb_scan_arbiter_if;
  logic       fb_rst;
  logic       fb_rst_complete;
  logic       fb_re;
  logic       fb_r_mode;
  logic [7:0] fb_r_xpos;
  logic [7:0] fb_r_ypos;
  logic [7:0] fb_dout;
  logic       fb_r_data_valid;
  logic       fb_we;
  logic [7:0] fb_w_xpos;
  logic [7:0] fb_w_ypos;
  logic [7:0] fb_din;
  logic       fb_w_data_valid;

  modport master (
    output fb_rst, fb_re, fb_r_mode, fb_r_xpos, fb_r_ypos,
    output fb_we, fb_w_xpos, fb_w_ypos, fb_din,
    input  fb_rst_complete, fb_dout, fb_r_data_valid, fb_w_data_valid
  );

  modport slave (
    input  fb_rst, fb_re, fb_r_mode, fb_r_xpos, fb_r_ypos,
    input  fb_we, fb_w_xpos, fb_w_ypos, fb_din,
    output fb_rst_complete, fb_dout, fb_r_data_valid, fb_w_data_valid
  );
endinterface

// File: rtl/fb_scan_arbiter.sv
// rtl/fb_scan_arbiter.sv - arbitrates framebuffer port between page/column scan-out, draw writes and clears
module fb_scan_arbiter
  import fb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  output logic       frame_busy,
  output logic       frame_done,
  output logic [7:0] px_data,
  output logic       px_valid,
  input  logic       px_ready,
  input  logic       draw_req,
  input  logic [7:0] draw_x,
  input  logic [7:0] draw_y,
  input  logic [7:0] draw_data,
  output logic       draw_ack,
  input  logic       clear_req,
  fb_scan_arbiter_if.master fb
);

  fb_state_t         state;
  logic [COL_W-1:0]  col;
  logic [PAGE_W-1:0] page;
  logic [CNT_W-1:0]  acc_cnt;
  logic              scan_rd;
  logic              clear_pend;
  logic              last_rd;

  logic px_take;
  logic draw_oob;
  logic rd_elig;
  logic wr_elig;
  logic grant_wr;
  logic last_col;
  logic last_page;

  assign px_take   = px_valid && px_ready;
  assign draw_oob  = (draw_x >= 8'(H_PIXELS)) || (draw_y >= 8'(V_PIXELS));
  assign rd_elig   = scan_rd && (!px_valid || px_ready);
  // draw_ack still high means the client has not yet seen the previous completion
  assign wr_elig   = draw_req && !draw_ack && !draw_oob;
  assign grant_wr  = wr_elig && (!rd_elig || last_rd);
  assign last_col  = (col == COL_W'(H_PIXELS - 1));
  assign last_page = (page == PAGE_W'(PAGES - 1));

  assign fb.fb_r_mode = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= INIT_RST;
      col          <= '0;
      page         <= '0;
      acc_cnt      <= '0;
      scan_rd      <= 1'b0;
      clear_pend   <= 1'b0;
      last_rd      <= 1'b0;
      frame_busy   <= 1'b0;
      frame_done   <= 1'b0;
      px_data      <= 8'h00;
      px_valid     <= 1'b0;
      draw_ack     <= 1'b0;
      fb.fb_rst    <= 1'b0;
      fb.fb_re     <= 1'b0;
      fb.fb_r_xpos <= 8'h00;
      fb.fb_r_ypos <= 8'h00;
      fb.fb_we     <= 1'b0;
      fb.fb_w_xpos <= 8'h00;
      fb.fb_w_ypos <= 8'h00;
      fb.fb_din    <= 8'h00;
    end else begin
      fb.fb_rst  <= 1'b0;
      draw_ack   <= 1'b0;
      frame_done <= 1'b0;

      if (px_take) begin
        px_valid <= 1'b0;
        if (acc_cnt == CNT_W'(BYTES_PER_FRAME - 1)) begin
          frame_done <= 1'b1;
          frame_busy <= 1'b0;
          acc_cnt    <= '0;
        end else begin
          acc_cnt <= acc_cnt + 1'b1;
        end
      end

      if (state != INIT_RST && state != INIT_WAIT && frame_start && !frame_busy) begin
        frame_busy <= 1'b1;
        scan_rd    <= 1'b1;
        col        <= '0;
        page       <= '0;
        acc_cnt    <= '0;
      end

      case (state)
        INIT_RST, CLR_RST: begin
          fb.fb_rst <= 1'b1;
          state     <= (state == INIT_RST) ? INIT_WAIT : CLR_WAIT;
        end
        INIT_WAIT, CLR_WAIT: begin
          if (fb.fb_rst_complete) state <= IDLE;
        end
        IDLE: begin
          if (draw_req && !draw_ack && draw_oob) draw_ack <= 1'b1;
          if (clear_pend && !frame_busy && !frame_start) begin
            clear_pend <= 1'b0;
            state      <= CLR_RST;
          end else if (grant_wr) begin
            fb.fb_we     <= 1'b1;
            fb.fb_w_xpos <= draw_x;
            fb.fb_w_ypos <= draw_y;
            fb.fb_din    <= draw_data;
            state        <= WR;
          end else if (rd_elig) begin
            fb.fb_re     <= 1'b1;
            fb.fb_r_xpos <= 8'(col);
            fb.fb_r_ypos <= 8'({page, 3'b000});
            state        <= RD;
          end
        end
        RD: begin
          if (fb.fb_r_data_valid) begin
            fb.fb_re <= 1'b0;
            px_data  <= fb.fb_dout;
            px_valid <= 1'b1;
            last_rd  <= 1'b1;
            state    <= GAP;
            if (last_col) begin
              col  <= '0;
              page <= page + 1'b1;
              if (last_page) scan_rd <= 1'b0;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        WR: begin
          if (fb.fb_w_data_valid) begin
            fb.fb_we <= 1'b0;
            draw_ack <= 1'b1;
            last_rd  <= 1'b0;
            state    <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= INIT_RST;
        end
      endcase

      // latched after the state update so a request coinciding with clear entry is kept
      if (state != INIT_RST && state != INIT_WAIT && clear_req) clear_pend <= 1'b1;
    end
  end

endmodule

// File: doc/fb_scan_arbiter.md
FB_SCAN_ARBITER -- requirements
Module: fb_scan_arbiter
Interface
REQ-001 H_PIXELS, 128, framebuffer width in pixels (columns per page).
REQ-002 V_PIXELS, 64, framebuffer height; pages = V_PIXELS/8.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 frame_start  in  1  one-cycle pulse requesting one full-frame scan.
REQ-006 frame_busy  out  1  high from accepted frame_start until frame_done.
REQ-007 frame_done  out  1  one-cycle pulse after the last frame byte is accepted.
REQ-008 px_data  out  8  column byte, bit0 = top row of page.
REQ-009 px_valid  out  1  px_data valid; held until px_ready.
REQ-010 px_ready  in  1  stream sink accepts byte when px_valid&&px_ready.
REQ-011 draw_req  in  1  level; draw client write request, inputs held until draw_ack.
REQ-012 draw_x  in  8  write pixel x (any alignment).
REQ-013 draw_y  in  8  write pixel row.
REQ-014 draw_data  in  8  8 horizontal pixels, MSB leftmost.
REQ-015 draw_ack  out  1  one-cycle pulse: draw completed or dropped.
REQ-016 clear_req  in  1  one-cycle pulse requesting framebuffer clear.
REQ-017 fb_rst  out  1  active-high framebuffer clear pulse.
REQ-018 fb_rst_complete  in  1  framebuffer clear finished.
REQ-019 fb_re  out  1  framebuffer read enable (level).
REQ-020 fb_r_mode  out  1  tied 1 (column read).
REQ-021 fb_r_xpos  out  8  scan column.
REQ-022 fb_r_ypos  out  8  page*8.
REQ-023 fb_dout  in  8  framebuffer read data.
REQ-024 fb_r_data_valid  in  1  read data valid.
REQ-025 fb_we  out  1  framebuffer write enable (level).
REQ-026 fb_w_xpos  out  8  registered draw_x.
REQ-027 fb_w_ypos  out  8  registered draw_y.
REQ-028 fb_din  out  8  registered draw_data.
REQ-029 fb_w_data_valid  in  1  write accepted.
Function
REQ-030 FSM states INIT_RST, INIT_WAIT, IDLE, RD, WR, GAP, CLR_RST, CLR_WAIT; fb_re and fb_we never high together.
REQ-031 INIT_RST: fb_rst high one cycle -> INIT_WAIT; INIT_WAIT exits to IDLE on fb_rst_complete; frame_start, draw_req, clear_req ignored until IDLE (not latched).
REQ-032 RD: fb_re held high, addresses stable, until fb_r_data_valid; capture fb_dout into one-entry output register, drop fb_re, enter GAP (fb_re/fb_we low exactly one cycle) -> IDLE.
REQ-033 WR: fb_we held high, fb_w_*/fb_din stable, until fb_w_data_valid; pulse draw_ack same cycle as fb_we drop, enter GAP.
REQ-034 Scan order page 0..pages-1, column 0..H_PIXELS-1 within page; 1024 bytes per frame at defaults; column/page counters advance on each RD capture, page increments on column wrap.
REQ-035 RD issued from IDLE only when scan active and output register empty or being accepted this cycle.
REQ-036 Arbitration round-robin: when both RD eligible and draw_req pending, grant alternates, last-served loses; single requester always granted.
REQ-037 draw_x>=H_PIXELS or draw_y>=V_PIXELS: draw_ack pulses from IDLE with no fb_we.
REQ-038 frame_done pulses the cycle after the 1024th px_valid&&px_ready; frame_start while frame_busy ignored.
REQ-039 clear_req latched pending; serviced from IDLE only when no scan active (CLR_RST/CLR_WAIT as init); draws held off, unacked, during clear.
Reset
REQ-040 On rst_n low: all outputs 0 (px_data 0, fb_r_mode 1), counters 0, pending flags cleared, state INIT_RST; reset mid-scan abandons frame without frame_done.
REQ-041 Release synchronous to clk; first post-reset cycle drives fb_rst high.
Structure
REQ-042 Package fb_pkg: H_PIXELS, V_PIXELS, BYTES_PER_FRAME, FSM state enum.
REQ-043 Single module, no sub-modules; shares fb_pkg with framebuffer users.
Verification
REQ-044 Reset release, fb_rst_complete after 1024 cycles -> exactly one fb_rst pulse, IDLE, no fb_re/fb_we before.
REQ-045 Framebuffer byte (x=8,y=0)=0xFF, frame_start, px_ready=1 -> stream byte index 8 = 0x01, index 0 = 0x00, 1024 bytes, frame_done once.
REQ-046 px_ready low 50 cycles mid-frame -> px_data stable, at most one RD outstanding, no byte lost or duplicated.
REQ-047 draw_req held continuously during scan -> RD and WR grants alternate; draw(x=3,y=5,0xA5) readback column bits match.
REQ-048 draw_x=200 -> draw_ack within 3 cycles, fb_we never asserted.
REQ-049 clear_req mid-frame -> clear starts only after frame_done; rst_n low mid-RD -> fb_re low immediately, no frame_done.
